// File: rtl/echo_pkg.sv
// Shared types, FSM state encoding and saturation helper for the echo mixer.
package echo_pkg;

  localparam int unsigned ECHO_W  = 16;
  localparam int unsigned ECHO_CW = 8;

  typedef logic signed [ECHO_W-1:0] sample_t;
  typedef logic        [ECHO_CW-1:0] coef_t;

  typedef enum logic [2:0] {
    IDLE,
    M_DRY,
    M_WET,
    M_FB,
    SAT
  } echo_mix_state_t;

  // Clamp a value carrying two guard bits down to a W-bit sample.
  function automatic sample_t sat_w(input logic signed [ECHO_W+1:0] v);
    if ((v[ECHO_W+1:ECHO_W-1] == 3'b000) || (v[ECHO_W+1:ECHO_W-1] == 3'b111))
      return v[ECHO_W-1:0];
    else if (v[ECHO_W+1])
      return {1'b1, {(ECHO_W-1){1'b0}}};
    else
      return {1'b0, {(ECHO_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/echo_mix_cv_to_coef.sv
// CV to coefficient: jack-detect default, negative clamp, top-bit slice.
module cv_to_coef
  import echo_pkg::*;
#(
  parameter int W       = 16,
  parameter int CW      = 8,
  parameter int DEFAULT = 128
) (
  input  logic signed [W-1:0]  cv,
  input  logic                 present,
  output logic        [CW-1:0] coef
);

  always_comb begin
    coef = '0;
    if (!present)
      coef = CW'(DEFAULT);
    else if (cv[W-1])
      coef = '0;
    else
      coef = CW'(cv >>> (W - 1 - CW));
  end

endmodule

// File: rtl/echo_mix.sv
// Wet/dry crossfade and feedback stage sharing one multiplier across three products.
module echo_mix
  import echo_pkg::*;
#(
  parameter int W           = 16,
  parameter int CW          = 8,
  parameter int DEFAULT_MIX = 128,
  parameter int DEFAULT_FB  = 96
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                strobe,
  input  logic signed [W-1:0] dry_in,
  input  logic signed [W-1:0] wet_in,
  input  logic signed [W-1:0] mix_cv,
  input  logic signed [W-1:0] fb_cv,
  input  logic                mix_cv_present,
  input  logic                fb_cv_present,
  output logic signed [W-1:0] mix_out,
  output logic signed [W-1:0] fb_out,
  output logic                out_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int PW = W + CW + 1;
  localparam int AW = W + CW + 2;

  echo_mix_state_t state, state_next;

  logic        [CW-1:0] m_coef, f_coef;
  logic        [CW-1:0] m_q, f_q;
  logic signed [W-1:0]  dry_q, wet_q;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] mix_sum;
  logic signed [W+1:0]  mix_raw;
  logic signed [W:0]    fb_raw;
  logic signed [W:0]    fbp;

  logic signed [W-1:0]  mul_a;
  logic        [CW:0]   mul_b;
  logic signed [PW-1:0] prod;

  cv_to_coef #(.W(W), .CW(CW), .DEFAULT(DEFAULT_MIX)) u_mix_coef (
    .cv      (mix_cv),
    .present (mix_cv_present),
    .coef    (m_coef)
  );

  cv_to_coef #(.W(W), .CW(CW), .DEFAULT(DEFAULT_FB)) u_fb_coef (
    .cv      (fb_cv),
    .present (fb_cv_present),
    .coef    (f_coef)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (strobe) state_next = M_DRY;
      M_DRY:   state_next = M_WET;
      M_WET:   state_next = M_FB;
      M_FB:    state_next = SAT;
      SAT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Coefficient operand is zero-extended; the 2^CW - m term needs the extra bit.
  always_comb begin
    mul_a = dry_q;
    mul_b = '0;
    case (state)
      M_DRY: begin
        mul_a = dry_q;
        mul_b = {1'b1, {CW{1'b0}}} - {1'b0, m_q};
      end
      M_WET: begin
        mul_a = wet_q;
        mul_b = {1'b0, m_q};
      end
      M_FB: begin
        mul_a = wet_q;
        mul_b = {1'b0, f_q};
      end
      default: ;
    endcase
  end

  assign prod    = PW'(mul_a) * PW'($signed({1'b0, mul_b}));
  assign mix_sum = acc + AW'(prod);
  assign fbp     = (W+1)'(prod >>> CW);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dry_q     <= '0;
      wet_q     <= '0;
      m_q       <= '0;
      f_q       <= '0;
      acc       <= '0;
      mix_raw   <= '0;
      fb_raw    <= '0;
      mix_out   <= '0;
      fb_out    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= (state == SAT);
      if (strobe && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (strobe) begin
            dry_q <= dry_in;
            wet_q <= wet_in;
            m_q   <= m_coef;
            f_q   <= f_coef;
          end
        end
        M_DRY: acc <= AW'(prod);
        M_WET: begin
          acc     <= mix_sum;
          mix_raw <= (W+2)'(mix_sum >>> CW);
        end
        M_FB:  fb_raw <= (W+1)'(dry_q) + fbp;
        SAT: begin
          mix_out <= sat_w(mix_raw);
          fb_out  <= sat_w({fb_raw[W], fb_raw});
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_mix.sv
// Self-checking bench for echo_mix against an arithmetic reference model.
module tb_echo_mix;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               strobe = 1'b0;
  logic signed [15:0] dry_in = '0, wet_in = '0, mix_cv = '0, fb_cv = '0;
  logic               mix_cv_present = 1'b0, fb_cv_present = 1'b0;
  logic signed [15:0] mix_out, fb_out;
  logic               out_valid, busy, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  echo_mix #(.W(16), .CW(8), .DEFAULT_MIX(128), .DEFAULT_FB(96)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .strobe         (strobe),
    .dry_in         (dry_in),
    .wet_in         (wet_in),
    .mix_cv         (mix_cv),
    .fb_cv          (fb_cv),
    .mix_cv_present (mix_cv_present),
    .fb_cv_present  (fb_cv_present),
    .mix_out        (mix_out),
    .fb_out         (fb_out),
    .out_valid      (out_valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  // Reference model: gain c means c/256, coefficient from the top CV bits.
  function automatic int coef(input int cv, input bit present, input int dflt);
    if (!present) return dflt;
    if (cv < 0) return 0;
    return cv / 128;
  endfunction

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int model_mix(input int dry, input int wet, input int m);
    longint s;
    s = longint'(dry) * (256 - m) + longint'(wet) * m;
    return sat16(s >>> 8);
  endfunction

  function automatic int model_fb(input int dry, input int wet, input int f);
    longint p;
    p = longint'(wet) * f;
    return sat16(longint'(dry) + (p >>> 8));
  endfunction

  function automatic int rnd_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic drive(input int dry, input int wet, input int mcv, input int fcv,
                       input bit mp, input bit fp);
    dry_in = 16'(dry);
    wet_in = 16'(wet);
    mix_cv = 16'(mcv);
    fb_cv  = 16'(fcv);
    mix_cv_present = mp;
    fb_cv_present  = fp;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    strobe = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_outputs(input string name, input int em, input int ef);
    logic signed [15:0] exp_m, exp_f;
    exp_m = 16'(em);
    exp_f = 16'(ef);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid: got %b expected 1", name, out_valid);
    end
    n_checks++;
    if (mix_out !== exp_m) begin
      n_fail++;
      $display("FAIL %s mix_out: got %0d expected %0d", name, mix_out, exp_m);
    end
    n_checks++;
    if (fb_out !== exp_f) begin
      n_fail++;
      $display("FAIL %s fb_out: got %0d expected %0d", name, fb_out, exp_f);
    end
  endtask

  // Strobe at the current negedge, scramble inputs afterwards, expect result 5 cycles later.
  task automatic run_sample(input string name, input int dry, input int wet,
                            input int mcv, input int fcv, input bit mp, input bit fp);
    int m, f;
    m = coef(mcv, mp, 128);
    f = coef(fcv, fp, 96);
    drive(dry, wet, mcv, fcv, mp, fp);
    strobe = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        strobe = 1'b0;
        drive(rnd_s16(), rnd_s16(), rnd_s16(), rnd_s16(), 1'(($urandom & 1)), 1'(($urandom & 1)));
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s busy: got %b expected 1", name, busy);
        end
      end
      if (i < 5) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s early out_valid at cycle %0d: got %b expected 0", name, i, out_valid);
        end
      end
    end
    check_outputs(name, model_mix(dry, wet, m), model_fb(dry, wet, f));
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy after: got %b expected 0", name, busy);
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s stray out_valid: got %b expected 0", name, out_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mix_out, fb_out, out_valid, busy, overrun} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset: got mix=%0d fb=%0d v=%b busy=%b ovr=%b expected all 0",
               mix_out, fb_out, out_valid, busy, overrun);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_defaults();
    run_sample("defaults", 1000, 2000, 0, 0, 1'b0, 1'b0);
    expect_quiet("defaults_hold", 3);
    n_checks++;
    if (mix_out !== 16'sd1500 || fb_out !== 16'sd1750) begin
      n_fail++;
      $display("FAIL defaults_hold: got mix=%0d fb=%0d expected 1500 1750", mix_out, fb_out);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    run_sample("sat_pos", 30000, 30000, 0, 32767, 1'b0, 1'b1);
    n_checks++;
    if (fb_out !== 16'sd32767) begin
      n_fail++;
      $display("FAIL sat_pos_const: got %0d expected 32767", fb_out);
    end
    @(negedge clk);
    run_sample("sat_neg", -30000, -30000, 0, 32767, 1'b0, 1'b1);
    n_checks++;
    if (fb_out !== -16'sd32768) begin
      n_fail++;
      $display("FAIL sat_neg_const: got %0d expected -32768", fb_out);
    end
    @(negedge clk);
    run_sample("mix_max", -32768, 32767, 32767, 0, 1'b1, 1'b1);
  endtask

  task automatic test_neg_clamp();
    @(negedge clk);
    run_sample("neg_clamp", 1234, -800, -5000, 0, 1'b1, 1'b0);
    n_checks++;
    if (mix_out !== 16'sd1234) begin
      n_fail++;
      $display("FAIL neg_clamp_const: got %0d expected 1234", mix_out);
    end
    @(negedge clk);
    run_sample("f_zero", -4321, 9999, 0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      run_sample("random", rnd_s16(), rnd_s16(), rnd_s16(), rnd_s16(),
                 1'(($urandom & 1)), 1'(($urandom & 1)));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 8; k++)
      run_sample("back_to_back", rnd_s16(), rnd_s16(), int'($urandom_range(0, 32767)),
                 rnd_s16(), 1'b1, 1'(($urandom & 1)));
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back overrun: got %b expected 0", overrun);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    drive(500, -700, 0, 0, 1'b0, 1'b0);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    @(negedge clk);
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_early: got %b expected 0", overrun);
    end
    drive(-20000, 20000, 32767, 32767, 1'b1, 1'b1);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_early_valid: got %b expected 0", out_valid);
    end
    @(negedge clk);
    check_outputs("overrun_result", model_mix(500, -700, 128), model_fb(500, -700, 96));
    expect_quiet("overrun_no_restart", 8);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got %b expected 1", overrun);
    end
  endtask

  task automatic test_sat_strobe();
    do_reset();
    drive(3000, 1000, 0, 0, 1'b0, 1'b0);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    repeat (3) @(negedge clk);
    drive(-9000, 8000, 1000, 1000, 1'b1, 1'b1);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    check_outputs("sat_cycle_strobe", model_mix(3000, 1000, 128), model_fb(3000, 1000, 96));
    expect_quiet("sat_cycle_ignored", 8);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_cycle_overrun: got %b expected 1", overrun);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_sample("pre_mid_reset", 1000, 2000, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    drive(-15000, 12000, 0, 0, 1'b0, 1'b0);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({mix_out, fb_out, out_valid, busy, overrun} !== 35'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got mix=%0d fb=%0d v=%b busy=%b ovr=%b expected all 0",
               mix_out, fb_out, out_valid, busy, overrun);
    end
    expect_quiet("mid_reset_quiet", 8);
    run_sample("post_mid_reset", -15000, 12000, 20000, 16000, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_saturation();
    test_neg_clamp();
    test_random();
    test_back_to_back();
    test_overrun();
    test_sat_strobe();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
